// File: rtl/udma_mram_erase_seq.sv
`default_nettype none
// ============================================================================
// Module   : udma_mram_erase_seq
// Brief    : Erase / reference-line-init command sequencer for the uDMA MRAM
//            peripheral. Turns one register-interface trigger into a series of
//            word/sector erase (or a single ref-line init) commands issued to
//            the MRAM macro over valid/ready + done, and reports pending flags
//            and per-event done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module udma_mram_erase_seq #(
    parameter int GAP_CYCLES = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int SIZE_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  trigger_i,
    output logic                  trigger_ack_o,
    input  logic [31:0]           mode_i,
    input  logic [ADDR_WIDTH-1:0] erase_addr_i,
    input  logic [SIZE_WIDTH-1:0] erase_size_i,
    output logic                  mram_cmd_valid_o,
    output logic [1:0]            mram_cmd_op_o,
    output logic [ADDR_WIDTH-1:0] mram_cmd_addr_o,
    input  logic                  mram_cmd_ready_i,
    input  logic                  mram_done_i,
    input  logic                  mram_err_i,
    output logic                  erase_pending_o,
    output logic                  ref_line_pending_o,
    output logic [3:0]            event_done_o
);

    // Gap counter holds GAP_CYCLES-1 at most; keep at least one bit.
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam int               CNT_W    = SIZE_WIDTH + 1;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_WORD    = 2'b01;
    localparam logic [1:0] OP_SECTOR  = 2'b10;
    localparam logic [1:0] OP_REFLINE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       idx_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   valid_q;
    logic                   ack_q;
    logic                   erase_pend_q;
    logic                   ref_pend_q;
    logic [3:0]             event_q;

    logic [1:0]             trig_op_d;
    logic                   trig_ok_d;
    logic [CNT_W-1:0]       idx_inc_d;
    logic [ADDR_WIDTH-1:0]  addr_cur_d;
    logic [ADDR_WIDTH-1:0]  addr_inc_d;

    // Only the low three mode bits carry meaning.
    logic unused_mode_bits;
    assign unused_mode_bits = ^mode_i[31:3];

    // Decode the one-hot mode and decide whether the trigger can be accepted.
    always_comb begin
        trig_op_d = OP_NONE;
        case (mode_i[2:0])
            3'b001:  trig_op_d = OP_WORD;
            3'b010:  trig_op_d = OP_SECTOR;
            3'b100:  trig_op_d = OP_REFLINE;
            default: trig_op_d = OP_NONE;
        endcase
        // Ref-line init ignores the size; erases need at least one unit.
        trig_ok_d = (trig_op_d == OP_REFLINE) ||
                    ((trig_op_d != OP_NONE) && (erase_size_i != '0));
    end

    // Command address for the current index and for the one after it;
    // the sum wraps naturally at ADDR_WIDTH.
    always_comb begin
        idx_inc_d  = idx_q + CNT_W'(1);
        addr_cur_d = base_q + ADDR_WIDTH'(idx_q);
        addr_inc_d = base_q + ADDR_WIDTH'(idx_inc_d);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NONE;
            base_q       <= '0;
            cmd_addr_q   <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            valid_q      <= 1'b0;
            ack_q        <= 1'b0;
            erase_pend_q <= 1'b0;
            ref_pend_q   <= 1'b0;
            event_q      <= 4'b0000;
        end else begin
            ack_q   <= 1'b0;
            event_q <= 4'b0000;

            // A trigger while busy is refused without disturbing the sequence.
            if (trigger_i && (state_q != S_IDLE)) begin
                event_q[3] <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (trigger_i) begin
                        if (trig_ok_d) begin
                            ack_q        <= 1'b1;
                            op_q         <= trig_op_d;
                            base_q       <= erase_addr_i;
                            cnt_q        <= {1'b0, erase_size_i};
                            idx_q        <= '0;
                            valid_q      <= 1'b1;
                            cmd_addr_q   <= (trig_op_d == OP_REFLINE) ? '0 : erase_addr_i;
                            erase_pend_q <= (trig_op_d != OP_REFLINE);
                            ref_pend_q   <= (trig_op_d == OP_REFLINE);
                            state_q      <= S_ISSUE;
                        end else begin
                            event_q[3] <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    if (mram_cmd_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (mram_done_i) begin
                        if (mram_err_i) begin
                            event_q[2] <= 1'b1;
                            state_q    <= S_FINISH;
                        end else begin
                            idx_q <= idx_inc_d;
                            if ((idx_inc_d == cnt_q) || (op_q == OP_REFLINE)) begin
                                event_q[1] <= (op_q == OP_REFLINE);
                                event_q[0] <= (op_q != OP_REFLINE);
                                state_q    <= S_FINISH;
                            end else if (GAP_CYCLES == 0) begin
                                valid_q    <= 1'b1;
                                cmd_addr_q <= addr_inc_d;
                                state_q    <= S_ISSUE;
                            end else begin
                                gap_q   <= GAP_LOAD;
                                state_q <= S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_q == '0) begin
                        valid_q    <= 1'b1;
                        cmd_addr_q <= addr_cur_d;
                        state_q    <= S_ISSUE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end

                S_FINISH: begin
                    erase_pend_q <= 1'b0;
                    ref_pend_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign trigger_ack_o      = ack_q;
    assign mram_cmd_valid_o   = valid_q;
    assign mram_cmd_op_o      = op_q;
    assign mram_cmd_addr_o    = cmd_addr_q;
    assign erase_pending_o    = erase_pend_q;
    assign ref_line_pending_o = ref_pend_q;
    assign event_done_o       = event_q;

endmodule
`default_nettype wire

// File: tb/tb_udma_mram_erase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_mram_erase_seq
// Brief    : Directed scoreboard bench for udma_mram_erase_seq. Expected
//            commands and event pulses are queued when stimulus is driven and
//            popped as the DUT produces them; a small macro model answers
//            each accepted command with done five cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_mram_erase_seq;

    localparam int GAP      = 4;
    localparam int DONE_LAT = 5;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        trigger_i = 1'b0;
    logic        trigger_ack_o;
    logic [31:0] mode_i = '0;
    logic [15:0] erase_addr_i = '0;
    logic [9:0]  erase_size_i = '0;
    logic        mram_cmd_valid_o;
    logic [1:0]  mram_cmd_op_o;
    logic [15:0] mram_cmd_addr_o;
    logic        mram_cmd_ready_i = 1'b1;
    logic        mram_done_i = 1'b0;
    logic        mram_err_i = 1'b0;
    logic        erase_pending_o;
    logic        ref_line_pending_o;
    logic [3:0]  event_done_o;

    udma_mram_erase_seq #(
        .GAP_CYCLES (GAP),
        .ADDR_WIDTH (16),
        .SIZE_WIDTH (10)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn_i),
        .trigger_i          (trigger_i),
        .trigger_ack_o      (trigger_ack_o),
        .mode_i             (mode_i),
        .erase_addr_i       (erase_addr_i),
        .erase_size_i       (erase_size_i),
        .mram_cmd_valid_o   (mram_cmd_valid_o),
        .mram_cmd_op_o      (mram_cmd_op_o),
        .mram_cmd_addr_o    (mram_cmd_addr_o),
        .mram_cmd_ready_i   (mram_cmd_ready_i),
        .mram_done_i        (mram_done_i),
        .mram_err_i         (mram_err_i),
        .erase_pending_o    (erase_pending_o),
        .ref_line_pending_o (ref_line_pending_o),
        .event_done_o       (event_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
    } cmd_t;

    typedef struct {
        logic [3:0] ev;
        int         cyc;
    } ev_t;

    cmd_t cmd_q[$];
    ev_t  ev_q[$];

    int         cyc          = 0;
    int         done_at      = -1;
    int         exp_rise     = -1;
    int         n_done       = 0;
    int         err_at       = 0;
    int         fin_cyc      = -1;
    int         pend_low_cyc = -1;
    bit         prev_valid   = 1'b0;
    bit         act_erase    = 1'b0;
    bit         act_ref      = 1'b0;
    logic [3:0] fin_ev       = 4'b0000;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock step: sampled mid-cycle on the falling edge. Also acts as the
    // macro model and pops the scoreboards.
    task automatic tick();
        cmd_t c;
        ev_t  e;
        @(negedge clk);
        cyc++;
        trigger_i   = 1'b0;
        mram_done_i = 1'b0;
        mram_err_i  = 1'b0;

        if (mram_cmd_valid_o && !prev_valid && (exp_rise >= 0)) begin
            chk("valid_rise_cycle", cyc, exp_rise);
            exp_rise = -1;
        end
        prev_valid = mram_cmd_valid_o;

        if (mram_cmd_valid_o && mram_cmd_ready_i) begin
            if (cmd_q.size() == 0) begin
                chk("unexpected_cmd_pending", cmd_q.size(), 1);
            end else begin
                c = cmd_q.pop_front();
                chk("cmd_op", mram_cmd_op_o, c.op);
                chk("cmd_addr", mram_cmd_addr_o, c.addr);
            end
            done_at = cyc + DONE_LAT;
        end

        if (cyc == done_at) begin
            done_at     = -1;
            mram_done_i = 1'b1;
            n_done++;
            if (n_done == err_at) begin
                mram_err_i   = 1'b1;
                e.ev         = 4'b0100;
                e.cyc        = cyc + 1;
                ev_q.push_back(e);
                fin_cyc      = cyc + 1;
                pend_low_cyc = cyc + 2;
            end else if (cmd_q.size() == 0) begin
                e.ev         = fin_ev;
                e.cyc        = cyc + 1;
                ev_q.push_back(e);
                fin_cyc      = cyc + 1;
                pend_low_cyc = cyc + 2;
            end else begin
                exp_rise = cyc + GAP + 1;
            end
        end

        if (event_done_o !== 4'b0000) begin
            if (ev_q.size() == 0) begin
                chk("unexpected_event", event_done_o, 4'b0000);
            end else begin
                e = ev_q.pop_front();
                chk("event_value", event_done_o, e.ev);
                chk("event_cycle", cyc, e.cyc);
            end
        end

        if (act_erase) chk("erase_pending_high", erase_pending_o, 1'b1);
        if (act_ref)   chk("ref_pending_high", ref_line_pending_o, 1'b1);
        if (cyc == fin_cyc) begin
            act_erase = 1'b0;
            act_ref   = 1'b0;
        end
        if (cyc == pend_low_cyc) begin
            chk("erase_pending_low", erase_pending_o, 1'b0);
            chk("ref_pending_low", ref_line_pending_o, 1'b0);
        end
    endtask

    // Drive an accepted trigger in the current cycle and queue its commands.
    task automatic start_seq(input logic [2:0] mode, input logic [15:0] addr,
                             input logic [9:0] size, input int n_cmds, input int err_on);
        cmd_t c;
        mode_i       = {29'd0, mode};
        erase_addr_i = addr;
        erase_size_i = size;
        trigger_i    = 1'b1;
        n_done       = 0;
        err_at       = err_on;
        pend_low_cyc = -1;
        fin_cyc      = -1;
        for (int i = 0; i < n_cmds; i++) begin
            case (mode)
                3'b001:  c.op = 2'b01;
                3'b010:  c.op = 2'b10;
                default: c.op = 2'b11;
            endcase
            c.addr = (mode == 3'b100) ? 16'h0000 : addr + 16'(i);
            cmd_q.push_back(c);
        end
        fin_ev    = (mode == 3'b100) ? 4'b0010 : 4'b0001;
        act_erase = (mode != 3'b100);
        act_ref   = (mode == 3'b100);
        tick();
        chk("trigger_ack", trigger_ack_o, 1'b1);
        chk("valid_at_T1", mram_cmd_valid_o, 1'b1);
        // Inputs changing after acceptance must not matter.
        mode_i       = 32'h0000_0002;
        erase_addr_i = 16'h5555;
        erase_size_i = 10'd1;
    endtask

    // Step until the sequence has drained, stopping on the pending-low cycle.
    task automatic run_seq();
        int n = 0;
        while (!((cmd_q.size() == 0) && (ev_q.size() == 0) && (done_at < 0) &&
                 (pend_low_cyc >= 0) && (cyc >= pend_low_cyc)) && (n < 1000)) begin
            tick();
            n++;
        end
        chk("seq_completed_in_budget", (n < 1000), 1'b1);
    endtask

    task automatic reject_trig(input logic [2:0] mode, input logic [9:0] size);
        ev_t e;
        tick();
        mode_i       = {29'd0, mode};
        erase_addr_i = 16'h0100;
        erase_size_i = size;
        trigger_i    = 1'b1;
        e.ev  = 4'b1000;
        e.cyc = cyc + 1;
        ev_q.push_back(e);
        tick();
        chk("reject_no_ack", trigger_ack_o, 1'b0);
        chk("reject_no_valid", mram_cmd_valid_o, 1'b0);
        chk("reject_no_pending", erase_pending_o | ref_line_pending_o, 1'b0);
        repeat (3) tick();
        chk("reject_event_drained", ev_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, mram_cmd_valid_o, 1'b0);
        chk({tag, "_op"}, mram_cmd_op_o, 2'b00);
        chk({tag, "_addr"}, mram_cmd_addr_o, 16'h0000);
        chk({tag, "_ack"}, trigger_ack_o, 1'b0);
        chk({tag, "_erase_pend"}, erase_pending_o, 1'b0);
        chk({tag, "_ref_pend"}, ref_line_pending_o, 1'b0);
        chk({tag, "_event"}, event_done_o, 4'b0000);
    endtask

    initial begin
        ev_t e;
        int  n;

        // Reset state.
        repeat (3) tick();
        chk_all_zero("reset");
        rstn_i = 1'b1;
        tick();

        // Word erase, three units, gap timing checked between commands.
        tick();
        start_seq(3'b001, 16'h0010, 10'd3, 3, 0);
        run_seq();

        // Sector erase wrapping past 0xFFFF, triggered on the pending-low cycle.
        start_seq(3'b010, 16'hFFFE, 10'd3, 3, 0);
        run_seq();

        // Ref-line init: a single command at address 0 regardless of size.
        start_seq(3'b100, 16'h1234, 10'd7, 1, 0);
        run_seq();

        // Invalid mode and zero-size erase are refused.
        reject_trig(3'b011, 10'd3);
        reject_trig(3'b001, 10'd0);

        // Second trigger while waiting for done is refused; sequence unchanged.
        tick();
        start_seq(3'b001, 16'h0020, 10'd2, 2, 0);
        n = 0;
        while ((cmd_q.size() != 1) && (n < 100)) begin
            tick();
            n++;
        end
        chk("first_cmd_accepted", cmd_q.size(), 1);
        tick();
        mode_i       = 32'h0000_0004;
        erase_addr_i = 16'h0777;
        erase_size_i = 10'd9;
        trigger_i    = 1'b1;
        e.ev  = 4'b1000;
        e.cyc = cyc + 1;
        ev_q.push_back(e);
        run_seq();

        // Macro error on the second done of a four-unit erase.
        start_seq(3'b001, 16'h0030, 10'd4, 2, 2);
        run_seq();
        repeat (12) tick();
        chk("no_cmd_after_error", mram_cmd_valid_o, 1'b0);

        // Reset while in the gap, then restart from index 0.
        start_seq(3'b001, 16'h0040, 10'd3, 3, 0);
        n = 0;
        while ((n_done != 1) && (n < 100)) begin
            tick();
            n++;
        end
        chk("first_done_seen", n_done, 1);
        tick();
        tick();
        rstn_i = 1'b0;
        #1;
        chk_all_zero("async_reset");
        cmd_q.delete();
        ev_q.delete();
        done_at      = -1;
        exp_rise     = -1;
        fin_cyc      = -1;
        pend_low_cyc = -1;
        act_erase    = 1'b0;
        act_ref      = 1'b0;
        repeat (2) tick();
        chk("reset_held_event", event_done_o, 4'b0000);
        rstn_i = 1'b1;
        tick();
        start_seq(3'b001, 16'h0040, 10'd2, 2, 0);
        run_seq();
        repeat (3) tick();
        chk("final_cmd_queue_empty", cmd_q.size(), 0);
        chk("final_event_queue_empty", ev_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
